branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Direction predictor paired with the branch comparison unit.
- In IF it issues a taken/not-taken prediction per PC from a table of 2-bit saturating counters.
- In EX it takes the resolved branch outcome (the comparison unit's taken select), trains the table and detects mispredictions.
- On a misprediction it issues a registered flush and redirect PC to the fetch stage.

Parameters:
- PC_WIDTH, 64, width of all PC/target buses.
- INDEX_BITS, 6, table index width; table depth = 2**INDEX_BITS entries.
- CNT_WIDTH, 32, width of the branch and mispredict statistics counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state while low.
- if_pc  input  PC_WIDTH  fetch-stage PC to predict.
- if_pred_taken  output  1  combinational prediction for if_pc.
- ex_valid  input  1  a conditional branch is resolving in EX this cycle.
- ex_pc  input  PC_WIDTH  PC of the resolving branch.
- ex_taken  input  1  resolved outcome from the branch comparison unit.
- ex_pred_taken  input  1  prediction originally issued for this branch, carried down the pipeline.
- ex_target  input  PC_WIDTH  computed branch target (PC + immediate).
- flush  output  1  registered one-cycle pulse: squash IF/ID/EX younger instructions.
- redirect_pc  output  PC_WIDTH  registered fetch redirect; valid while flush=1.
- branch_count  output  CNT_WIDTH  resolved branches since reset.
- mispredict_count  output  CNT_WIDTH  mispredictions since reset.

Behaviour:
- Index = pc[INDEX_BITS+1:2]; pc[1:0] ignored.
- Table: 2**INDEX_BITS entries × 2 bits. All entries reset to 2'b01 (weakly not-taken).
- if_pred_taken = table[index(if_pc)][1]; purely combinational, zero latency.
- Training, on each clock edge with ex_valid=1:
  - ex_taken=1: entry increments, saturating at 2'b11.
  - ex_taken=0: entry decrements, saturating at 2'b00.
  - ex_valid=0: no table change.
- Same-cycle read/write hazard: when index(if_pc)==index(ex_pc) with ex_valid=1, if_pred_taken reflects the pre-update value. There is no bypass; the update is visible from the next cycle.
- Mispredict = ex_valid & (ex_taken != ex_pred_taken). The table's current state does not affect mispredict; only the carried prediction counts.
- flush/redirect timing: both are registered and appear the cycle after the mispredicting EX cycle.
  - flush=1 for exactly one cycle per mispredict.
  - Back-to-back mispredicts give consecutive flush pulses.
- redirect_pc value:
  - ex_taken=1: ex_target.
  - ex_taken=0: ex_pc + 4, modulo 2**PC_WIDTH (wraps at the top of the address space).
- When flush=0, redirect_pc holds its last value; it is 0 after reset.
- Statistics:
  - branch_count increments on every ex_valid cycle.
  - mispredict_count increments on every mispredict cycle.
  - Both saturate at 2**CNT_WIDTH-1 (no wrap).
- Reset values: table=2'b01 all entries, flush=0, redirect_pc=0, branch_count=0, mispredict_count=0. if_pred_taken therefore reads 0 during and after reset.
- Reset mid-operation: a pending flush is discarded, and the table and counters clear immediately (asynchronous). The first edge after release trains normally.
- Unknown or non-branch instructions must not assert ex_valid. The upstream pipeline gates ex_valid with the branch opcode and with its own flush.

Test Plan:
- Reset then read: release reset, sweep if_pc=0x0..0xFC step 4 -> if_pred_taken=0 for all; flush=0; both counters=0.
- Saturation up: 3 cycles ex_valid=1, ex_pc=0x40, ex_taken=1, ex_pred_taken=1 -> if_pc=0x40 predicts 1 after the 1st update. Entry=2'b11 after the 2nd and stays 2'b11. No flush; branch_count=3.
- Mispredict taken: ex_pc=0x100, ex_taken=1, ex_pred_taken=0, ex_target=0x80 -> next cycle flush=1, redirect_pc=0x80; following cycle flush=0; mispredict_count=1.
- Mispredict not-taken with wrap: ex_pc=0xFFFF_FFFF_FFFF_FFFC, ex_taken=0, ex_pred_taken=1 -> flush=1, redirect_pc=0x0.
- Aliasing and hazard: ex_pc=0x10 trains taken while if_pc=0x110 (same index) in the same cycle -> if_pred_taken=0 that cycle, 1 the next cycle.
- Async reset mid-flush: assert reset low between the mispredict edge and the following edge -> flush drops to 0 immediately, counters=0, entry for 0x10 back to 2'b01.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch direction predictor: a table of 2-bit saturating counters indexed by PC,
// trained on resolved EX branches, with a registered flush/redirect on mispredict and branch statistics.
module branch_predictor #(
  parameter int PC_WIDTH   = 64,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 if_pred_taken,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic                 ex_taken,
  input  logic                 ex_pred_taken,
  input  logic [PC_WIDTH-1:0]  ex_target,
  output logic                 flush,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]            table_r [DEPTH];
  logic [INDEX_BITS-1:0] if_idx_s;
  logic [INDEX_BITS-1:0] ex_idx_s;
  logic [1:0]            ex_entry_s;
  logic [1:0]            ex_entry_nxt_s;
  logic                  mispredict_s;
  logic [PC_WIDTH-1:0]   redirect_nxt_s;
  logic                  flush_r;
  logic [PC_WIDTH-1:0]   redirect_r;
  logic [CNT_WIDTH-1:0]  branch_count_r;
  logic [CNT_WIDTH-1:0]  mispredict_count_r;
  logic                  unused_if_pc_s;

  // Word-aligned PCs: the two byte-offset bits never select an entry.
  assign if_idx_s       = if_pc[INDEX_BITS+1:2];
  assign ex_idx_s       = ex_pc[INDEX_BITS+1:2];
  assign unused_if_pc_s = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2], if_pc[1:0]};
  assign ex_entry_s     = table_r[ex_idx_s];

  // No bypass: a same-cycle update to this entry is seen only from the next cycle.
  assign if_pred_taken  = table_r[if_idx_s][1];

  // Saturating counter step, mispredict detection and redirect target selection
  always_comb begin
    ex_entry_nxt_s = ex_entry_s;
    if (ex_taken) begin
      if (ex_entry_s != 2'b11) begin
        ex_entry_nxt_s = ex_entry_s + 2'b01;
      end else begin
        ex_entry_nxt_s = ex_entry_s;
      end
    end else begin
      if (ex_entry_s != 2'b00) begin
        ex_entry_nxt_s = ex_entry_s - 2'b01;
      end else begin
        ex_entry_nxt_s = ex_entry_s;
      end
    end
    mispredict_s = ex_valid & (ex_taken ^ ex_pred_taken);
    if (ex_taken) begin
      redirect_nxt_s = ex_target;
    end else begin
      redirect_nxt_s = ex_pc + PC_WIDTH'(3'd4);
    end
  end

  // Counter table: all entries weakly not-taken out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= 2'b01;
      end
    end else if (ex_valid) begin
      table_r[ex_idx_s] <= ex_entry_nxt_s;
    end
  end

  // Registered flush pulse and redirect; redirect holds between mispredicts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_r    <= 1'b0;
      redirect_r <= '0;
    end else begin
      flush_r <= mispredict_s;
      if (mispredict_s) begin
        redirect_r <= redirect_nxt_s;
      end
    end
  end

  // Saturating branch and mispredict statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count_r     <= '0;
      mispredict_count_r <= '0;
    end else begin
      if (ex_valid && (branch_count_r != CNT_MAX)) begin
        branch_count_r <= branch_count_r + CNT_WIDTH'(1'b1);
      end
      if (mispredict_s && (mispredict_count_r != CNT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + CNT_WIDTH'(1'b1);
      end
    end
  end

  assign flush            = flush_r;
  assign redirect_pc      = redirect_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule
